// File: rtl/uart_rx_top_module.sv
// UART receiver: 16x oversampled deserialiser with start/parity/stop checking.
// Optional build macro UART_RX_MAJORITY_VOTE_EN enables 2-of-3 voting per bit.
module uart_rx_top_module #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] baud_rate,
   input  logic [1:0] parity_type,
   input  logic       rx_in,
   output logic [7:0] dout,
   output logic       done,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int DIV_2400  = CLK_FREQ / (2400 * OVERSAMPLE);
   localparam int DIV_4800  = CLK_FREQ / (4800 * OVERSAMPLE);
   localparam int DIV_9600  = CLK_FREQ / (9600 * OVERSAMPLE);
   localparam int DIV_19200 = CLK_FREQ / (19200 * OVERSAMPLE);
   localparam int DIV_W     = $clog2(DIV_2400 + 1);

   localparam logic [DIV_W-1:0] DMAX_2400  = DIV_W'(DIV_2400 - 1);
   localparam logic [DIV_W-1:0] DMAX_4800  = DIV_W'(DIV_4800 - 1);
   localparam logic [DIV_W-1:0] DMAX_9600  = DIV_W'(DIV_9600 - 1);
   localparam logic [DIV_W-1:0] DMAX_19200 = DIV_W'(DIV_19200 - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

`ifdef UART_RX_MAJORITY_VOTE_EN
   // Every bit is decided at tick 8 after voting over ticks 6, 7 and 8; the
   // tick count free-runs across bits so every window lines up on bit edges.
   localparam logic [3:0] START_PT      = 4'd8;
   localparam logic [3:0] DATA_PT       = 4'd8;
   localparam logic       RESTART_TICKS = 1'b0;
`else
   // Start sampled at its centre, then the count restarts so tick 15 is the
   // centre of each following bit.
   localparam logic [3:0] START_PT      = 4'd7;
   localparam logic [3:0] DATA_PT       = 4'd15;
   localparam logic       RESTART_TICKS = 1'b1;
`endif

   logic [1:0]       sync_reg;
   logic             rx_prev_reg;
   logic [2:0]       state_reg,    state_next;
   logic [DIV_W-1:0] div_cnt_reg,  div_cnt_next;
   logic [DIV_W-1:0] div_max_reg,  div_max_next;
   logic [1:0]       par_mode_reg, par_mode_next;
   logic [3:0]       tick_cnt_reg, tick_cnt_next;
   logic [2:0]       bit_cnt_reg,  bit_cnt_next;
   logic [7:0]       shift_reg,    shift_next;
   logic             par_bad_reg,  par_bad_next;
   logic             stop_bad_reg, stop_bad_next;
   logic             finish_reg,   finish_next;
   logic [7:0]       dout_reg,     dout_next;
   logic             done_reg,     done_next;
   logic             perr_reg,     perr_next;
   logic             ferr_reg,     ferr_next;
   logic             busy_reg,     busy_next;

   logic rx_s;
   logic fall;
   logic tick;
   logic sample_now;
   logic bit_val;
   logic par_on;
   logic exp_par;

   assign rx_s = sync_reg[1];
   assign fall = rx_prev_reg & ~rx_s;
   assign tick = (state_reg != IDLE) && (div_cnt_reg == div_max_reg);
   assign sample_now = tick &&
      (tick_cnt_reg == ((state_reg == START) ? START_PT : DATA_PT));
   assign par_on  = (par_mode_reg == 2'b01) || (par_mode_reg == 2'b10);
   assign exp_par = (par_mode_reg == 2'b01) ? ~^shift_reg : ^shift_reg;

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic samp6_reg;
   logic samp7_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         samp6_reg <= 1'b1;
         samp7_reg <= 1'b1;
      end else if (tick) begin
         if (tick_cnt_reg == 4'd6) samp6_reg <= rx_s;
         if (tick_cnt_reg == 4'd7) samp7_reg <= rx_s;
      end
   end

   assign bit_val = (samp6_reg & samp7_reg) | (samp6_reg & rx_s) | (samp7_reg & rx_s);
`else
   assign bit_val = rx_s;
`endif

   function automatic logic [DIV_W-1:0] div_max_for(input logic [1:0] sel);
      case (sel)
         2'b00:   div_max_for = DMAX_2400;
         2'b01:   div_max_for = DMAX_4800;
         2'b10:   div_max_for = DMAX_9600;
         default: div_max_for = DMAX_19200;
      endcase
   endfunction

   always_comb begin
      state_next    = state_reg;
      div_cnt_next  = div_cnt_reg;
      div_max_next  = div_max_reg;
      par_mode_next = par_mode_reg;
      tick_cnt_next = tick_cnt_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      par_bad_next  = par_bad_reg;
      stop_bad_next = stop_bad_reg;
      finish_next   = 1'b0;
      dout_next     = dout_reg;
      done_next     = 1'b0;
      perr_next     = perr_reg;
      ferr_next     = ferr_reg;
      busy_next     = busy_reg;

      if (state_reg != IDLE) begin
         div_cnt_next = tick ? '0 : div_cnt_reg + 1'b1;
         if (tick) tick_cnt_next = tick_cnt_reg + 4'd1;
      end

      // Result is published one cycle after the stop sample.
      if (finish_reg) begin
         dout_next = shift_reg;
         done_next = 1'b1;
         perr_next = par_bad_reg;
         ferr_next = stop_bad_reg;
         busy_next = 1'b0;
      end

      case (state_reg)
         IDLE: begin
            if (fall) begin
               state_next    = START;
               div_max_next  = div_max_for(baud_rate);
               par_mode_next = parity_type;
               div_cnt_next  = '0;
               tick_cnt_next = '0;
               bit_cnt_next  = '0;
               par_bad_next  = 1'b0;
               busy_next     = 1'b1;
            end
         end
         START: begin
            if (sample_now) begin
               if (bit_val) begin
                  state_next = IDLE;
                  busy_next  = 1'b0;
               end else begin
                  state_next = DATA;
                  if (RESTART_TICKS) tick_cnt_next = '0;
               end
            end
         end
         DATA: begin
            if (sample_now) begin
               shift_next   = {bit_val, shift_reg[7:1]};
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) state_next = par_on ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (sample_now) begin
               par_bad_next = bit_val ^ exp_par;
               state_next   = STOP;
            end
         end
         STOP: begin
            if (sample_now) begin
               stop_bad_next = ~bit_val;
               finish_next   = 1'b1;
               state_next    = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_reg     <= 2'b11;
         rx_prev_reg  <= 1'b1;
         state_reg    <= IDLE;
         div_cnt_reg  <= '0;
         div_max_reg  <= '0;
         par_mode_reg <= 2'b00;
         tick_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         par_bad_reg  <= 1'b0;
         stop_bad_reg <= 1'b0;
         finish_reg   <= 1'b0;
         dout_reg     <= '0;
         done_reg     <= 1'b0;
         perr_reg     <= 1'b0;
         ferr_reg     <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         sync_reg     <= {sync_reg[0], rx_in};
         rx_prev_reg  <= rx_s;
         state_reg    <= state_next;
         div_cnt_reg  <= div_cnt_next;
         div_max_reg  <= div_max_next;
         par_mode_reg <= par_mode_next;
         tick_cnt_reg <= tick_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         par_bad_reg  <= par_bad_next;
         stop_bad_reg <= stop_bad_next;
         finish_reg   <= finish_next;
         dout_reg     <= dout_next;
         done_reg     <= done_next;
         perr_reg     <= perr_next;
         ferr_reg     <= ferr_next;
         busy_reg     <= busy_next;
      end
   end

   assign dout       = dout_reg;
   assign done       = done_reg;
   assign parity_err = perr_reg;
   assign frame_err  = ferr_reg;
   assign busy       = busy_reg;

endmodule
